bp_cfg_loader: RTL
==================

Name: bp_cfg_loader

Overview:
- Boot-time config sequencer that drives the per-core config link (cfg_core/cfg_addr/cfg_data bus) consumed by each tile.
- Widths and core count come from the active bp_proc_param_s config.
- On start, for every core in turn: freeze, program core id, stream CCE microcode from an external sync ROM, set CCE mode to normal, unfreeze.
- Then asserts done.

Parameters:
- num_core_p, 1, cores to program (iterated 0..num_core_p-1).
- cfg_core_width_p, 8, core-select field width.
- cfg_addr_width_p, 16, config address width.
- cfg_data_width_p, 32, config data width.
- num_cce_instr_ram_els_p, 256, microcode words per core (N).
- cce_instr_width_p, 32, ROM word width; must be <= cfg_data_width_p, zero-extended onto cfg_data_o.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  pulse to begin sequence; ignored unless in e_idle or e_done.
- done_o  out  1  sequence complete; sticky until next accepted start_i.
- cfg_v_o  out  1  config write valid.
- cfg_ready_i  in  1  consumer accepts when cfg_v_o & cfg_ready_i.
- cfg_core_o  out  cfg_core_width_p  target core.
- cfg_addr_o  out  cfg_addr_width_p  config address.
- cfg_data_o  out  cfg_data_width_p  write data.
- rom_addr_o  out  clog2(N)  microcode ROM address.
- rom_data_i  in  cce_instr_width_p  ROM data, valid 1 cycle after rom_addr_o.
- stall_cnt_o  out  32  stall count (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate, including mid-sequence): state=e_idle; outputs cleared as follows:
  - cfg_v_o=0, done_o=0, core/ucode indices=0, cfg_core_o/addr/data=0, rom_addr_o=0, stall_cnt_o=0.
  - No partial write survives reset.
- Addresses (package enum):
  - FREEZE=0x0001
  - CORE_ID=0x0002
  - CCE_MODE=0x0003
  - UCODE_BASE=0x8000; ucode word i goes to UCODE_BASE+i.
- FSM states: e_idle, e_freeze, e_core_id, e_fetch, e_load, e_ucode, e_mode, e_unfreeze, e_done.
  - e_idle --start_i--> e_freeze.
  - e_freeze: cfg_v_o=1, addr FREEZE, data 1 --accept--> e_core_id.
  - e_core_id: addr CORE_ID, data=core idx zero-extended --accept--> e_fetch.
  - e_fetch: rom_addr_o=ucode idx, cfg_v_o=0 --> e_load.
  - e_load: register rom_data_i into data reg --> e_ucode.
  - e_ucode: addr UCODE_BASE+idx, data=data reg --accept--> if idx==N-1 then idx=0, e_mode; else idx+1, e_fetch.
  - e_mode: addr CCE_MODE, data 1 --accept--> e_unfreeze.
  - e_unfreeze: addr FREEZE, data 0 --accept--> if core==num_core_p-1 then e_done; else core+1, e_freeze.
  - e_done: done_o=1; start_i clears done_o, resets indices --> e_freeze.
- cfg_core_o = current core index in every state.
- Handshake: while cfg_v_o & !cfg_ready_i, cfg_core_o/addr/data held stable and cfg_v_o stays high. No combinational path from cfg_ready_i to cfg_v_o.
- Timing: each microcode word takes 3 cycles with ready always high. Per core, with ready high: 2 + 3N + 2 cycles from e_freeze to leaving e_unfreeze.
- Wrap-around:
  - ucode index compares against N-1, never rolls over.
  - core index likewise against num_core_p-1.
  - N=1 valid: single fetch/load/ucode pass.
- start_i while busy (not e_idle/e_done): ignored, no effect on sequence.
- start_i coincident with reset deassertion edge: ignored that cycle.

Optional Feature:
- Macro BP_CFG_LOADER_STALL_CNT_EN.
- Defined: stall_cnt_o is a 32-bit saturating counter (sticks at 0xFFFF_FFFF).
  - Increments every cycle with cfg_v_o & !cfg_ready_i.
  - Cleared on reset and on accepted start_i.
- Undefined: no counter logic; stall_cnt_o tied to 0.

Decomposition:
- Shared package bp_cfg_link_pkg:
  - bp_cfg_addr_e (FREEZE, CORE_ID, CCE_MODE, UCODE_BASE).
  - bp_cfg_loader_state_e.
  - struct bp_cfg_bus_s {core, addr, data} sized from cfg_*_width.
  - CCE mode constant e_cce_mode_normal=1.
- Single flat module; no sub-module warranted. Stall counter is inline.

Test Plan:
- Basic: num_core_p=1, N=4, ROM[i]=0xA0+i, ready tied 1, pulse start_i. Expect exactly 8 accepted writes, in order:
  - (0x0001,1), (0x0002,0)
  - (0x8000,0xA0) .. (0x8003,0xA3)
  - (0x0003,1), (0x0001,0)
  - done_o rises 16 cycles after e_freeze entry.
- Backpressure: same setup, ready low 5 cycles during the 0x8002 write. Expect:
  - core/addr/data stable throughout, no duplicate or dropped write.
  - With macro: stall_cnt_o=5. Without macro: stall_cnt_o=0.
- Multi-core: num_core_p=2, N=2. Expect 12 writes: first 6 with cfg_core_o=0, next 6 with cfg_core_o=1 and CORE_ID data=1; then done_o=1.
- Reset mid-ucode: assert reset_n_i low while in e_ucode idx=2. Expect:
  - cfg_v_o=0 asynchronously.
  - After release plus start_i, sequence restarts at core 0 FREEZE write.
- Start ignored/restart: start_i pulsed during e_ucode has no effect. start_i in e_done clears done_o next cycle and replays the full sequence.
- Saturation (macro on): force ready=0 for 2^32 cycles, or preload the counter via hierarchical deposit to 0xFFFF_FFFE then stall 3 cycles. Expect stall_cnt_o holds 0xFFFF_FFFF.

Source files
------------

// File: rtl/bp_cfg_link_pkg.sv
// Shared definitions for the per-core config link: address map, loader FSM
// states, the cfg bus record and the CCE mode encoding.
package bp_cfg_link_pkg;

   localparam int cfg_core_width_gp = 8;
   localparam int cfg_addr_width_gp = 16;
   localparam int cfg_data_width_gp = 32;

   typedef enum logic [15:0] {
      e_cfg_addr_freeze     = 16'h0001,
      e_cfg_addr_core_id    = 16'h0002,
      e_cfg_addr_cce_mode   = 16'h0003,
      e_cfg_addr_ucode_base = 16'h8000
   } bp_cfg_addr_e;

   typedef enum logic [1:0] {
      e_cce_mode_uncached = 2'd0,
      e_cce_mode_normal   = 2'd1
   } bp_cce_mode_e;

   typedef enum logic [3:0] {
      e_idle     = 4'd0,
      e_freeze   = 4'd1,
      e_core_id  = 4'd2,
      e_fetch    = 4'd3,
      e_load     = 4'd4,
      e_ucode    = 4'd5,
      e_mode     = 4'd6,
      e_unfreeze = 4'd7,
      e_done     = 4'd8
   } bp_cfg_loader_state_e;

   typedef struct packed {
      logic [cfg_core_width_gp-1:0] core;
      logic [cfg_addr_width_gp-1:0] addr;
      logic [cfg_data_width_gp-1:0] data;
   } bp_cfg_bus_s;

endpackage

// File: rtl/bp_cfg_loader.sv
// Boot-time config sequencer: freezes each core, loads CCE microcode from a sync ROM,
// sets normal mode and unfreezes. Optional stall counter: BP_CFG_LOADER_STALL_CNT_EN.
module bp_cfg_loader
   import bp_cfg_link_pkg::*;
#(
   parameter int num_core_p              = 1,
   parameter int cfg_core_width_p        = cfg_core_width_gp,
   parameter int cfg_addr_width_p        = cfg_addr_width_gp,
   parameter int cfg_data_width_p        = cfg_data_width_gp,
   parameter int num_cce_instr_ram_els_p = 256,
   parameter int cce_instr_width_p       = 32,
   localparam int ucode_idx_width_lp     = (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1
)
(
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          start_i,
   output logic                          done_o,
   output logic                          cfg_v_o,
   input  logic                          cfg_ready_i,
   output logic [cfg_core_width_p-1:0]   cfg_core_o,
   output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
   output logic [cfg_data_width_p-1:0]   cfg_data_o,
   output logic [ucode_idx_width_lp-1:0] rom_addr_o,
   input  logic [cce_instr_width_p-1:0]  rom_data_i,
   output logic [31:0]                   stall_cnt_o
);

   localparam int core_idx_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
   localparam logic [ucode_idx_width_lp-1:0] ucode_last_lp = ucode_idx_width_lp'(num_cce_instr_ram_els_p - 1);
   localparam logic [ucode_idx_width_lp-1:0] ucode_zero_lp = {ucode_idx_width_lp{1'b0}};
   localparam logic [ucode_idx_width_lp-1:0] ucode_one_lp  = ucode_idx_width_lp'(1);
   localparam logic [core_idx_width_lp-1:0]  core_last_lp  = core_idx_width_lp'(num_core_p - 1);
   localparam logic [core_idx_width_lp-1:0]  core_zero_lp  = {core_idx_width_lp{1'b0}};
   localparam logic [core_idx_width_lp-1:0]  core_one_lp   = core_idx_width_lp'(1);
   localparam logic [cfg_data_width_p-1:0]   data_zero_lp  = {cfg_data_width_p{1'b0}};
   localparam logic [cfg_data_width_p-1:0]   data_one_lp   = cfg_data_width_p'(1'b1);
   localparam logic [cfg_addr_width_p-1:0]   addr_zero_lp  = {cfg_addr_width_p{1'b0}};

   bp_cfg_loader_state_e            state_r;
   logic [core_idx_width_lp-1:0]    core_idx_r;
   logic [ucode_idx_width_lp-1:0]   ucode_idx_r;
   logic [ucode_idx_width_lp-1:0]   rom_addr_r;
   logic [cfg_addr_width_p-1:0]     cfg_addr_r;
   logic [cfg_data_width_p-1:0]     cfg_data_r;
   logic                            cfg_v_r;
   logic                            done_r;
   logic                            init_done_r;
   logic                            start_ok_s;
   logic                            accept_s;

   function automatic logic [cfg_addr_width_p-1:0] ucode_addr(input logic [ucode_idx_width_lp-1:0] idx);
      return cfg_addr_width_p'(e_cfg_addr_ucode_base) + cfg_addr_width_p'(idx);
   endfunction

   // Start is only honoured when idle/done and not on the first edge after reset release
   always_comb begin
      start_ok_s = 1'b0;
      accept_s   = cfg_v_r & cfg_ready_i;
      if (init_done_r && (state_r == e_idle || state_r == e_done)) begin
         start_ok_s = start_i;
      end else begin
         start_ok_s = 1'b0;
      end
   end

   // Sequencer FSM; every bus output is loaded on the transition into its state
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r     <= e_idle;
         core_idx_r  <= core_zero_lp;
         ucode_idx_r <= ucode_zero_lp;
         rom_addr_r  <= ucode_zero_lp;
         cfg_addr_r  <= addr_zero_lp;
         cfg_data_r  <= data_zero_lp;
         cfg_v_r     <= 1'b0;
         done_r      <= 1'b0;
         init_done_r <= 1'b0;
      end else begin
         init_done_r <= 1'b1;
         case (state_r)
            e_idle, e_done: begin
               if (start_ok_s) begin
                  state_r     <= e_freeze;
                  done_r      <= 1'b0;
                  core_idx_r  <= core_zero_lp;
                  ucode_idx_r <= ucode_zero_lp;
                  cfg_v_r     <= 1'b1;
                  cfg_addr_r  <= cfg_addr_width_p'(e_cfg_addr_freeze);
                  cfg_data_r  <= data_one_lp;
               end
            end
            e_freeze: begin
               if (accept_s) begin
                  state_r    <= e_core_id;
                  cfg_addr_r <= cfg_addr_width_p'(e_cfg_addr_core_id);
                  cfg_data_r <= cfg_data_width_p'(core_idx_r);
               end
            end
            e_core_id: begin
               if (accept_s) begin
                  state_r    <= e_fetch;
                  cfg_v_r    <= 1'b0;
                  rom_addr_r <= ucode_idx_r;
               end
            end
            e_fetch: begin
               state_r <= e_load;
            end
            e_load: begin
               state_r    <= e_ucode;
               cfg_v_r    <= 1'b1;
               cfg_addr_r <= ucode_addr(ucode_idx_r);
               cfg_data_r <= cfg_data_width_p'(rom_data_i);
            end
            e_ucode: begin
               if (accept_s) begin
                  if (ucode_idx_r == ucode_last_lp) begin
                     state_r     <= e_mode;
                     ucode_idx_r <= ucode_zero_lp;
                     cfg_addr_r  <= cfg_addr_width_p'(e_cfg_addr_cce_mode);
                     cfg_data_r  <= cfg_data_width_p'(e_cce_mode_normal);
                  end else begin
                     state_r     <= e_fetch;
                     cfg_v_r     <= 1'b0;
                     ucode_idx_r <= ucode_idx_r + ucode_one_lp;
                     rom_addr_r  <= ucode_idx_r + ucode_one_lp;
                  end
               end
            end
            e_mode: begin
               if (accept_s) begin
                  state_r    <= e_unfreeze;
                  cfg_addr_r <= cfg_addr_width_p'(e_cfg_addr_freeze);
                  cfg_data_r <= data_zero_lp;
               end
            end
            e_unfreeze: begin
               if (accept_s) begin
                  if (core_idx_r == core_last_lp) begin
                     state_r <= e_done;
                     cfg_v_r <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     state_r    <= e_freeze;
                     core_idx_r <= core_idx_r + core_one_lp;
                     cfg_addr_r <= cfg_addr_width_p'(e_cfg_addr_freeze);
                     cfg_data_r <= data_one_lp;
                  end
               end
            end
            default: begin
               state_r <= e_idle;
               cfg_v_r <= 1'b0;
            end
         endcase
      end
   end

   assign done_o     = done_r;
   assign cfg_v_o    = cfg_v_r;
   assign cfg_core_o = cfg_core_width_p'(core_idx_r);
   assign cfg_addr_o = cfg_addr_r;
   assign cfg_data_o = cfg_data_r;
   assign rom_addr_o = rom_addr_r;

`ifdef BP_CFG_LOADER_STALL_CNT_EN
   logic [31:0] stall_cnt_r;

   // Saturating count of cycles where the consumer holds off a valid write
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stall_cnt_r <= 32'd0;
      end else if (start_ok_s) begin
         stall_cnt_r <= 32'd0;
      end else if (cfg_v_r && !cfg_ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_r;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule
